// File: rtl/spram_arbiter.sv
// spram_arbiter: round-robin two-port front end for one SB_SPRAM256KA with idle sleep/wake control
//   clk, rst             : clock (also SPRAM CLOCK), synchronous active-high reset
//   pN_valid/ready       : request handshake, ready is combinational grant
//   pN_we/addr/wdata/wmask : request payload (write flag, word address, data, nibble enables)
//   pN_rvalid/rdata      : read result one cycle after a read grant
//   ram_*                : SPRAM primitive connections
//   sleeping             : 1 while in SLEEP or WAKE
module spram_arbiter #(
  parameter int IDLE_SLEEP = 1024,
  parameter int WAKE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_valid,
  input  logic        p1_valid,
  output logic        p0_ready,
  output logic        p1_ready,
  input  logic        p0_we,
  input  logic        p1_we,
  input  logic [13:0] p0_addr,
  input  logic [13:0] p1_addr,
  input  logic [15:0] p0_wdata,
  input  logic [15:0] p1_wdata,
  input  logic [3:0]  p0_wmask,
  input  logic [3:0]  p1_wmask,
  output logic        p0_rvalid,
  output logic        p1_rvalid,
  output logic [15:0] p0_rdata,
  output logic [15:0] p1_rdata,
  output logic [13:0] ram_addr,
  output logic [15:0] ram_wdata,
  output logic [3:0]  ram_maskwren,
  output logic        ram_wren,
  output logic        ram_cs,
  output logic        ram_standby,
  output logic        ram_sleep,
  output logic        ram_poweroff,
  input  logic [15:0] ram_rdata,
  output logic        sleeping
);
  localparam int IW = $clog2(IDLE_SLEEP + 1) + 1;
  localparam int WW = $clog2(WAKE_CYCLES + 1) + 1;
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_SLEEP == 0 ? 0 : IDLE_SLEEP - 1);
  localparam logic [WW-1:0] WAKE_LAST = WW'(WAKE_CYCLES < 1 ? 0 : WAKE_CYCLES - 1);
  typedef enum logic [1:0] {ACTIVE, SLEEP, WAKE} state_t;
  state_t state, state_nx;
  logic [IW-1:0] idle_cnt, idle_nx;
  logic [WW-1:0] wake_cnt, wake_nx;
  logic rr_last, g0, g1, any_valid;
  always_comb begin
    any_valid = p0_valid | p1_valid;
    g0 = state == ACTIVE && p0_valid && (!p1_valid || rr_last);
    g1 = state == ACTIVE && p1_valid && (!p0_valid || !rr_last);
    state_nx = state;
    idle_nx = '0;
    wake_nx = '0;
    case (state)
      ACTIVE: if (!any_valid) begin
        // the idle cycle that brings the count to IDLE_SLEEP is the last one in ACTIVE
        if (IDLE_SLEEP != 0 && idle_cnt == IDLE_LAST) state_nx = SLEEP;
        else idle_nx = IDLE_SLEEP == 0 ? '0 : idle_cnt + 1'b1;
      end
      SLEEP: state_nx = any_valid ? WAKE : SLEEP;
      WAKE: begin
        state_nx = wake_cnt == WAKE_LAST ? ACTIVE : WAKE;
        wake_nx = wake_cnt == WAKE_LAST ? '0 : wake_cnt + 1'b1;
      end
      default: state_nx = ACTIVE;
    endcase
  end
  assign p0_ready = g0;
  assign p1_ready = g1;
  assign ram_cs = g0 | g1;
  assign ram_addr = g1 ? p1_addr : p0_addr;
  assign ram_wdata = g1 ? p1_wdata : p0_wdata;
  assign ram_maskwren = g1 ? p1_wmask : p0_wmask;
  assign ram_wren = g1 ? p1_we : p0_we;
  assign ram_standby = 1'b0;
  assign ram_poweroff = 1'b1;
  assign ram_sleep = state == SLEEP;
  assign sleeping = state != ACTIVE;
  assign p0_rdata = ram_rdata;
  assign p1_rdata = ram_rdata;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACTIVE;
      idle_cnt <= '0;
      wake_cnt <= '0;
      rr_last <= 1'b1;
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
    end else begin
      state <= state_nx;
      idle_cnt <= idle_nx;
      wake_cnt <= wake_nx;
      if (g0 | g1) rr_last <= g1;
      p0_rvalid <= g0 & ~p0_we;
      p1_rvalid <= g1 & ~p1_we;
    end
  end
endmodule

// File: tb/tb_spram_arbiter.sv
// tb_spram_arbiter: directed bench for spram_arbiter with a behavioural SPRAM model
module tb_spram_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic p0_valid, p1_valid, p0_we, p1_we;
  logic [13:0] p0_addr, p1_addr;
  logic [15:0] p0_wdata, p1_wdata;
  logic [3:0] p0_wmask, p1_wmask;
  logic p0_ready, p1_ready, p0_rvalid, p1_rvalid;
  logic [15:0] p0_rdata, p1_rdata;
  logic [13:0] ram_addr;
  logic [15:0] ram_wdata, ram_rdata;
  logic [3:0] ram_maskwren;
  logic ram_wren, ram_cs, ram_standby, ram_sleep, ram_poweroff, sleeping;
  logic n_p0_ready, n_p1_ready, n_p0_rvalid, n_p1_rvalid;
  logic [15:0] n_p0_rdata, n_p1_rdata, n_ram_wdata;
  logic [13:0] n_ram_addr;
  logic [3:0] n_ram_maskwren;
  logic n_ram_wren, n_ram_cs, n_ram_standby, n_ram_sleep, n_ram_poweroff, n_sleeping;
  int vectors = 0;
  int errors = 0;
  logic [15:0] mem [0:16383];

  spram_arbiter #(.IDLE_SLEEP(8), .WAKE_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .p0_valid(p0_valid), .p1_valid(p1_valid), .p0_ready(p0_ready), .p1_ready(p1_ready),
    .p0_we(p0_we), .p1_we(p1_we), .p0_addr(p0_addr), .p1_addr(p1_addr),
    .p0_wdata(p0_wdata), .p1_wdata(p1_wdata), .p0_wmask(p0_wmask), .p1_wmask(p1_wmask),
    .p0_rvalid(p0_rvalid), .p1_rvalid(p1_rvalid), .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_maskwren(ram_maskwren), .ram_wren(ram_wren),
    .ram_cs(ram_cs), .ram_standby(ram_standby), .ram_sleep(ram_sleep), .ram_poweroff(ram_poweroff),
    .ram_rdata(ram_rdata), .sleeping(sleeping)
  );

  spram_arbiter #(.IDLE_SLEEP(0), .WAKE_CYCLES(4)) dut_ns (
    .clk(clk), .rst(rst),
    .p0_valid(p0_valid), .p1_valid(p1_valid), .p0_ready(n_p0_ready), .p1_ready(n_p1_ready),
    .p0_we(p0_we), .p1_we(p1_we), .p0_addr(p0_addr), .p1_addr(p1_addr),
    .p0_wdata(p0_wdata), .p1_wdata(p1_wdata), .p0_wmask(p0_wmask), .p1_wmask(p1_wmask),
    .p0_rvalid(n_p0_rvalid), .p1_rvalid(n_p1_rvalid), .p0_rdata(n_p0_rdata), .p1_rdata(n_p1_rdata),
    .ram_addr(n_ram_addr), .ram_wdata(n_ram_wdata), .ram_maskwren(n_ram_maskwren), .ram_wren(n_ram_wren),
    .ram_cs(n_ram_cs), .ram_standby(n_ram_standby), .ram_sleep(n_ram_sleep), .ram_poweroff(n_ram_poweroff),
    .ram_rdata(16'h0000), .sleeping(n_sleeping)
  );

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] nw, input logic [3:0] m);
    logic [15:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (m[i]) r[4*i +: 4] = nw[4*i +: 4];
    return r;
  endfunction

  always @(posedge clk) begin
    if (ram_cs && !ram_sleep) begin
      if (ram_wren) mem[ram_addr] <= merge(mem[ram_addr], ram_wdata, ram_maskwren);
      else ram_rdata <= mem[ram_addr];
    end
  end

  task automatic set_p0(input logic v, input logic we, input logic [13:0] a, input logic [15:0] d, input logic [3:0] m);
    p0_valid = v; p0_we = we; p0_addr = a; p0_wdata = d; p0_wmask = m;
  endtask

  task automatic set_p1(input logic v, input logic we, input logic [13:0] a, input logic [15:0] d, input logic [3:0] m);
    p1_valid = v; p1_we = we; p1_addr = a; p1_wdata = d; p1_wmask = m;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    set_p0(0, 0, 14'h0, 16'h0, 4'h0);
    set_p1(0, 0, 14'h0, 16'h0, 4'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    vectors++; if (p0_rvalid !== 1'b0) begin errors++; $display("FAIL reset_p0_rvalid got %b exp 0", p0_rvalid); end
    vectors++; if (p1_rvalid !== 1'b0) begin errors++; $display("FAIL reset_p1_rvalid got %b exp 0", p1_rvalid); end
    vectors++; if (ram_sleep !== 1'b0) begin errors++; $display("FAIL reset_ram_sleep got %b exp 0", ram_sleep); end
    vectors++; if (sleeping !== 1'b0) begin errors++; $display("FAIL reset_sleeping got %b exp 0", sleeping); end
    vectors++; if (ram_cs !== 1'b0) begin errors++; $display("FAIL reset_ram_cs got %b exp 0", ram_cs); end
    vectors++; if (ram_standby !== 1'b0) begin errors++; $display("FAIL reset_standby got %b exp 0", ram_standby); end
    vectors++; if (ram_poweroff !== 1'b1) begin errors++; $display("FAIL reset_poweroff got %b exp 1", ram_poweroff); end
  endtask

  task automatic test_write_read();
    do_reset();
    set_p0(1, 1, 14'h0010, 16'hA5C3, 4'b1111);
    #1;
    vectors++; if (p0_ready !== 1'b1) begin errors++; $display("FAIL wr_p0_ready got %b exp 1", p0_ready); end
    vectors++; if (p1_ready !== 1'b0) begin errors++; $display("FAIL wr_p1_ready got %b exp 0", p1_ready); end
    vectors++; if ({ram_cs, ram_wren} !== 2'b11) begin errors++; $display("FAIL wr_cs_wren got %b exp 11", {ram_cs, ram_wren}); end
    vectors++; if (ram_addr !== 14'h0010) begin errors++; $display("FAIL wr_ram_addr got %h exp 0010", ram_addr); end
    vectors++; if (ram_wdata !== 16'hA5C3) begin errors++; $display("FAIL wr_ram_wdata got %h exp a5c3", ram_wdata); end
    @(negedge clk);
    vectors++; if (p0_rvalid !== 1'b0) begin errors++; $display("FAIL wr_no_rvalid got %b exp 0", p0_rvalid); end
    set_p0(1, 0, 14'h0010, 16'h0000, 4'b1111);
    #1;
    vectors++; if (ram_wren !== 1'b0) begin errors++; $display("FAIL rd_ram_wren got %b exp 0", ram_wren); end
    @(negedge clk);
    set_p0(0, 0, 14'h0, 16'h0, 4'h0);
    vectors++; if (p0_rvalid !== 1'b1) begin errors++; $display("FAIL rd_p0_rvalid got %b exp 1", p0_rvalid); end
    vectors++; if (p0_rdata !== 16'hA5C3) begin errors++; $display("FAIL rd_p0_rdata got %h exp a5c3", p0_rdata); end
    vectors++; if (p1_rvalid !== 1'b0) begin errors++; $display("FAIL rd_p1_rvalid got %b exp 0", p1_rvalid); end
    @(negedge clk);
    vectors++; if (p0_rvalid !== 1'b0) begin errors++; $display("FAIL rd_single_pulse got %b exp 0", p0_rvalid); end
  endtask

  task automatic test_mask();
    do_reset();
    set_p0(1, 1, 14'h0010, 16'hFFFF, 4'b0101);
    #1;
    vectors++; if (ram_maskwren !== 4'b0101) begin errors++; $display("FAIL mask_maskwren got %b exp 0101", ram_maskwren); end
    @(negedge clk);
    set_p0(1, 0, 14'h0010, 16'h0000, 4'b1111);
    @(negedge clk);
    set_p0(0, 0, 14'h0, 16'h0, 4'h0);
    vectors++; if (p0_rdata !== 16'hAFCF || p0_rvalid !== 1'b1) begin errors++; $display("FAIL mask_rdata got %h/%b exp afcf/1", p0_rdata, p0_rvalid); end
  endtask

  task automatic test_back_to_back();
    logic        we_t [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [13:0] a_t  [4] = '{14'h0020, 14'h0020, 14'h0021, 14'h0021};
    logic [15:0] d_t  [4] = '{16'h1234, 16'h1234, 16'h5678, 16'h5678};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_p0(1, we_t[i], a_t[i], d_t[i], 4'b1111);
      #1;
      vectors++; if (p0_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d] got %b exp 1", i, p0_ready); end
      @(negedge clk);
      vectors++; if (p0_rvalid !== ~we_t[i]) begin errors++; $display("FAIL b2b_rvalid[%0d] got %b exp %b", i, p0_rvalid, ~we_t[i]); end
      if (!we_t[i]) begin
        vectors++; if (p0_rdata !== d_t[i]) begin errors++; $display("FAIL b2b_rdata[%0d] got %h exp %h", i, p0_rdata, d_t[i]); end
      end
    end
    set_p0(0, 0, 14'h0, 16'h0, 4'h0);
  endtask

  task automatic test_round_robin();
    do_reset();
    set_p0(1, 1, 14'h0001, 16'h1111, 4'b1111);
    @(negedge clk);
    set_p0(0, 0, 14'h0, 16'h0, 4'h0);
    set_p1(1, 1, 14'h0002, 16'h2222, 4'b1111);
    @(negedge clk);
    set_p1(0, 0, 14'h0, 16'h0, 4'h0);
    do_reset();
    set_p0(1, 0, 14'h0001, 16'h0, 4'b1111);
    set_p1(1, 0, 14'h0002, 16'h0, 4'b1111);
    for (int i = 0; i < 4; i++) begin
      #1;
      vectors++; if ({p1_ready, p0_ready} !== (i % 2 == 0 ? 2'b01 : 2'b10)) begin errors++; $display("FAIL rr_grant[%0d] got %b exp %b", i, {p1_ready, p0_ready}, (i % 2 == 0 ? 2'b01 : 2'b10)); end
      @(negedge clk);
      vectors++; if ({p1_rvalid, p0_rvalid} !== (i % 2 == 0 ? 2'b01 : 2'b10)) begin errors++; $display("FAIL rr_rvalid[%0d] got %b exp %b", i, {p1_rvalid, p0_rvalid}, (i % 2 == 0 ? 2'b01 : 2'b10)); end
      vectors++; if ((i % 2 == 0 ? p0_rdata : p1_rdata) !== (i % 2 == 0 ? 16'h1111 : 16'h2222)) begin errors++; $display("FAIL rr_rdata[%0d] got %h exp %h", i, (i % 2 == 0 ? p0_rdata : p1_rdata), (i % 2 == 0 ? 16'h1111 : 16'h2222)); end
    end
    set_p0(0, 0, 14'h0, 16'h0, 4'h0);
    set_p1(0, 0, 14'h0, 16'h0, 4'h0);
  endtask

  task automatic test_sleep_wake();
    do_reset();
    repeat (7) @(negedge clk);
    vectors++; if (ram_sleep !== 1'b0) begin errors++; $display("FAIL sleep_early got %b exp 0", ram_sleep); end
    @(negedge clk);
    vectors++; if ({ram_sleep, sleeping, ram_cs} !== 3'b110) begin errors++; $display("FAIL sleep_enter got %b exp 110", {ram_sleep, sleeping, ram_cs}); end
    set_p1(1, 0, 14'h0002, 16'h0, 4'b1111);
    #1;
    vectors++; if (p1_ready !== 1'b0) begin errors++; $display("FAIL sleep_ready got %b exp 0", p1_ready); end
    for (int w = 0; w < 4; w++) begin
      @(negedge clk);
      vectors++; if ({p1_ready, ram_sleep, sleeping} !== 3'b001) begin errors++; $display("FAIL wake[%0d] got %b exp 001", w, {p1_ready, ram_sleep, sleeping}); end
    end
    @(negedge clk);
    vectors++; if ({p1_ready, sleeping} !== 2'b10) begin errors++; $display("FAIL wake_grant got %b exp 10", {p1_ready, sleeping}); end
    @(negedge clk);
    set_p1(0, 0, 14'h0, 16'h0, 4'h0);
    vectors++; if (p1_rvalid !== 1'b1 || p1_rdata !== 16'h2222) begin errors++; $display("FAIL wake_rdata got %b/%h exp 1/2222", p1_rvalid, p1_rdata); end
  endtask

  task automatic test_idle_boundary();
    do_reset();
    repeat (7) @(negedge clk);
    set_p0(1, 1, 14'h0030, 16'h0, 4'b0000);
    #1;
    vectors++; if (p0_ready !== 1'b1) begin errors++; $display("FAIL bound_ready got %b exp 1", p0_ready); end
    @(negedge clk);
    set_p0(0, 0, 14'h0, 16'h0, 4'h0);
    vectors++; if (sleeping !== 1'b0) begin errors++; $display("FAIL bound_active got %b exp 0", sleeping); end
    repeat (7) @(negedge clk);
    vectors++; if (ram_sleep !== 1'b0) begin errors++; $display("FAIL bound_cleared got %b exp 0", ram_sleep); end
    @(negedge clk);
    vectors++; if (ram_sleep !== 1'b1) begin errors++; $display("FAIL bound_resleep got %b exp 1", ram_sleep); end
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    set_p0(1, 1, 14'h0010, 16'h0000, 4'b0000);
    @(negedge clk);
    set_p0(1, 0, 14'h0001, 16'h0, 4'b1111);
    #1;
    vectors++; if (p0_ready !== 1'b1) begin errors++; $display("FAIL rstrd_ready got %b exp 1", p0_ready); end
    rst = 1'b1;
    @(negedge clk);
    vectors++; if ({p1_rvalid, p0_rvalid} !== 2'b00) begin errors++; $display("FAIL rstrd_rvalid got %b exp 00", {p1_rvalid, p0_rvalid}); end
    rst = 1'b0;
    set_p1(1, 0, 14'h0002, 16'h0, 4'b1111);
    #1;
    vectors++; if ({p1_ready, p0_ready} !== 2'b01) begin errors++; $display("FAIL rstrd_tie got %b exp 01", {p1_ready, p0_ready}); end
    vectors++; if ({ram_sleep, sleeping} !== 2'b00) begin errors++; $display("FAIL rstrd_state got %b exp 00", {ram_sleep, sleeping}); end
    @(negedge clk);
    set_p0(0, 0, 14'h0, 16'h0, 4'h0);
    set_p1(0, 0, 14'h0, 16'h0, 4'h0);
    vectors++; if (p0_rvalid !== 1'b1 || p0_rdata !== 16'h1111) begin errors++; $display("FAIL rstrd_after got %b/%h exp 1/1111", p0_rvalid, p0_rdata); end
  endtask

  task automatic test_no_sleep();
    int hits = 0;
    do_reset();
    repeat (5000) begin
      @(negedge clk);
      if (n_ram_sleep !== 1'b0 || n_sleeping !== 1'b0) hits++;
    end
    vectors++; if (hits != 0) begin errors++; $display("FAIL nosleep_cycles got %0d exp 0", hits); end
  endtask

  initial begin
    set_p0(0, 0, 14'h0, 16'h0, 4'h0);
    set_p1(0, 0, 14'h0, 16'h0, 4'h0);
    test_reset();
    test_write_read();
    test_mask();
    test_back_to_back();
    test_round_robin();
    test_sleep_wake();
    test_idle_boundary();
    test_reset_mid_read();
    test_no_sleep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
